// File: rtl/dpe_arb_pkg.sv
// Shared definitions for the packet arbiters in front of the WireGuard
// encryptor (and, later, the decryptor).
package dpe_arb_pkg;

    // Arbiter control states:
    //   IDLE  - arbitration cycle, nothing is forwarded
    //   BUSY  - the granted port is forwarded beat by beat
    //   DRAIN - a truncated packet's remaining beats are swallowed
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    // Width of a beat counter able to hold 0..max_beats.
    function automatic int arb_cnt_w(input int max_beats);
        return $clog2(max_beats + 1);
    endfunction

endpackage

// File: rtl/dpe_rr_picker.sv
// Combinational round-robin picker: returns the first requesting index
// found when scanning upward from ptr+1, wrapping modulo N.
module dpe_rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_vld
);

    localparam int IDX_W = $clog2(N);

    logic [IDX_W-1:0] w_cand;

    // Scan ptr+1, ptr+2, ... ptr+N (mod N); the first hit wins, so the
    // port that was granted last has the lowest priority.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        w_cand  = '0;
        for (int i = 1; i <= N; i++) begin
            w_cand = IDX_W'((int'(ptr) + i) % N);
            if (!gnt_vld && req[w_cand]) begin
                gnt_idx = w_cand;
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dpe_wg_enc_arbiter.sv
// Packet-level round-robin arbiter sharing one encryptor among N ingress
// AXI-Stream-like ports. A grant lasts a whole packet and the granted index
// travels alongside it on out_tsrc. Packets longer than MAX_BEATS are cut
// (tlast forced on the last allowed beat) and their tail is drained.
//
// Handshake: a beat moves when valid & ready are both high in the same
// cycle; a source holding valid high without ready must keep data, keep and
// last unchanged. Output beats are a zero-latency combinational path from
// the granted input, and in_tready of that port is out_tready.
module dpe_wg_enc_arbiter
    import dpe_arb_pkg::*;
#(
    parameter int N_PORTS   = 4,
    parameter int DATA_W    = 64,
    parameter int MAX_BEATS = 192
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_PORTS*DATA_W-1:0]     in_tdata,
    input  logic [N_PORTS*DATA_W/8-1:0]   in_tkeep,
    input  logic [N_PORTS-1:0]            in_tlast,
    input  logic [N_PORTS-1:0]            in_tvalid,
    output logic [N_PORTS-1:0]            in_tready,
    output logic [DATA_W-1:0]             out_tdata,
    output logic [DATA_W/8-1:0]           out_tkeep,
    output logic                          out_tlast,
    output logic                          out_tvalid,
    input  logic                          out_tready,
    output logic [$clog2(N_PORTS)-1:0]    out_tsrc,
    input  logic [N_PORTS-1:0]            port_en,
    input  logic                          err_clr,
    output logic [N_PORTS-1:0]            err_oversize,
    output logic [31:0]                   pkt_cnt
);

    localparam int IDX_W  = $clog2(N_PORTS);
    localparam int KEEP_W = DATA_W / 8;
    localparam int CNT_W  = arb_cnt_w(MAX_BEATS);

    arb_state_t          r_state;
    logic [IDX_W-1:0]    r_grant;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [CNT_W-1:0]    r_beat_cnt;
    logic [N_PORTS-1:0]  r_err;
    logic [31:0]         r_pkt_cnt;

    logic [N_PORTS-1:0]  w_req;
    logic [IDX_W-1:0]    w_pick_idx;
    logic                w_pick_vld;
    logic [DATA_W-1:0]   w_sel_data;
    logic [KEEP_W-1:0]   w_sel_keep;
    logic                w_sel_last;
    logic                w_sel_valid;
    logic                w_cap_beat;
    logic                w_xfer;
    logic                w_trunc;
    logic                w_drain_end;

    assign w_req = in_tvalid & port_en;

    dpe_rr_picker #(.N(N_PORTS)) u_picker (
        .req     (w_req),
        .ptr     (r_rr_ptr),
        .gnt_idx (w_pick_idx),
        .gnt_vld (w_pick_vld)
    );

    assign w_sel_data  = in_tdata[r_grant*DATA_W +: DATA_W];
    assign w_sel_keep  = in_tkeep[r_grant*KEEP_W +: KEEP_W];
    assign w_sel_last  = in_tlast[r_grant];
    assign w_sel_valid = in_tvalid[r_grant];

    // The beat being offered is the last one a packet may carry.
    assign w_cap_beat  = (r_beat_cnt == CNT_W'(MAX_BEATS - 1));
    assign w_xfer      = (r_state == BUSY) && w_sel_valid && out_tready;
    assign w_trunc     = w_xfer && !w_sel_last && w_cap_beat;
    assign w_drain_end = (r_state == DRAIN) && w_sel_valid && w_sel_last;

    assign out_tsrc     = r_grant;
    assign err_oversize = r_err;
    assign pkt_cnt      = r_pkt_cnt;

    // Output mux and per-port ready: forward in BUSY, swallow in DRAIN.
    always_comb begin
        in_tready  = '0;
        out_tvalid = 1'b0;
        out_tdata  = '0;
        out_tkeep  = '0;
        out_tlast  = 1'b0;
        if (r_state == BUSY) begin
            in_tready[r_grant] = out_tready;
            out_tvalid         = w_sel_valid;
            out_tdata          = w_sel_data;
            out_tkeep          = w_sel_keep;
            out_tlast          = w_sel_last || w_cap_beat;
        end else if (r_state == DRAIN) begin
            in_tready[r_grant] = 1'b1;
        end
    end

    // FSM, grant/pointer, beat counter, sticky errors and packet counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rr_ptr   <= IDX_W'(N_PORTS - 1);
            r_grant    <= '0;
            r_beat_cnt <= '0;
            r_err      <= '0;
            r_pkt_cnt  <= '0;
        end else begin
            // Clear first so a same-cycle truncation still sets its bit.
            if (err_clr) begin
                r_err <= '0;
            end
            if (w_trunc) begin
                r_err[r_grant] <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_pick_vld) begin
                        r_grant    <= w_pick_idx;
                        r_rr_ptr   <= w_pick_idx;
                        r_beat_cnt <= '0;
                        r_state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_xfer) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (w_sel_last) begin
                            r_pkt_cnt <= r_pkt_cnt + 32'd1;
                            r_state   <= IDLE;
                        end else if (w_cap_beat) begin
                            r_pkt_cnt <= r_pkt_cnt + 32'd1;
                            r_state   <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_drain_end) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
